// File: rtl/feedback_arbiter.sv
// Grants the single tone/LED resource to Simon playback, the player or an event jingle.
// Define FEEDBACK_EVT_JINGLE_EN to build the EVENT state and its four-note jingle.
module feedback_arbiter #(
   parameter int unsigned MIN_HOLD = 4,
   parameter int unsigned GAP_CYC  = 2,
   parameter int unsigned NOTE_CYC = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sim_req,
   input  logic [1:0] sim_num,
   input  logic       ply_req,
   input  logic [1:0] ply_num,
   input  logic       evt_req,
   input  logic       evt_type,
   output logic [1:0] num,
   output logic       pressed,
   output logic [1:0] owner,
   output logic       evt_busy,
   output logic       evt_done
);

   localparam logic [15:0] MIN_HOLD_C = 16'(MIN_HOLD);
   localparam logic [15:0] GAP_CYC_C  = 16'(GAP_CYC);
   localparam logic [15:0] NOTE_CYC_C = 16'(NOTE_CYC);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SIMON,
      S_PLAYER,
      S_GAP
`ifdef FEEDBACK_EVT_JINGLE_EN
      , S_EVENT
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  num_q, num_d;
   logic        pressed_q, pressed_d;
   logic [1:0]  owner_q, owner_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [1:0]  idx_q, idx_d;
   logic        type_q, type_d;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      num_d   = num_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      idx_d   = idx_q;
      type_d  = type_q;

      unique case (state_q)
         S_IDLE: begin
            if (ply_req) begin
               state_d = S_PLAYER;
               cnt_d   = 16'd1;
               num_d   = ply_num;
            end else if (sim_req) begin
               state_d = S_SIMON;
               cnt_d   = 16'd1;
               num_d   = sim_num;
            end
         end
         S_SIMON: begin
            if (!sim_req && cnt_q >= MIN_HOLD_C) begin
               state_d = S_GAP;
               cnt_d   = 16'd1;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         S_PLAYER: begin
            if (!ply_req && cnt_q >= MIN_HOLD_C) begin
               state_d = S_GAP;
               cnt_d   = 16'd1;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         S_GAP: begin
            if (cnt_q >= GAP_CYC_C) begin
               state_d = S_IDLE;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
`ifdef FEEDBACK_EVT_JINGLE_EN
         S_EVENT: begin
            if (cnt_q >= NOTE_CYC_C) begin
               cnt_d = 16'd1;
               if (idx_q == 2'd3) begin
                  state_d = S_GAP;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
         end
      endcase

`ifdef FEEDBACK_EVT_JINGLE_EN
      // Jingle preempts any grant; re-triggers while playing are dropped.
      if (evt_req && state_q != S_EVENT) begin
         state_d = S_EVENT;
         cnt_d   = 16'd1;
         idx_d   = 2'd0;
         type_d  = evt_type;
         busy_d  = 1'b1;
      end
      if (state_d == S_EVENT) begin
         num_d = type_d ? idx_d : ~idx_d;
      end
`else
      done_d = evt_req;
`endif
   end

   always_comb begin
      pressed_d = 1'b0;
      owner_d   = 2'b00;
      unique case (state_d)
         S_SIMON: begin
            pressed_d = 1'b1;
            owner_d   = 2'b01;
         end
         S_PLAYER: begin
            pressed_d = 1'b1;
            owner_d   = 2'b10;
         end
`ifdef FEEDBACK_EVT_JINGLE_EN
         S_EVENT: begin
            pressed_d = 1'b1;
            owner_d   = 2'b11;
         end
`endif
         default: begin
            pressed_d = 1'b0;
            owner_d   = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 16'd0;
         num_q     <= 2'd0;
         pressed_q <= 1'b0;
         owner_q   <= 2'b00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         idx_q     <= 2'd0;
         type_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         num_q     <= num_d;
         pressed_q <= pressed_d;
         owner_q   <= owner_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         idx_q     <= idx_d;
         type_q    <= type_d;
      end
   end

`ifndef FEEDBACK_EVT_JINGLE_EN
   logic unused_evt;
   assign unused_evt = ^{evt_type, NOTE_CYC_C, idx_q, type_q};
`endif

   assign num      = num_q;
   assign pressed  = pressed_q;
   assign owner    = owner_q;
   assign evt_busy = busy_q;
   assign evt_done = done_q;

endmodule

// File: tb/tb_feedback_arbiter.sv
// Directed self-checking bench for feedback_arbiter at default parameters.
module tb_feedback_arbiter;

   logic       clk;
   logic       reset;
   logic       sim_req;
   logic [1:0] sim_num;
   logic       ply_req;
   logic [1:0] ply_num;
   logic       evt_req;
   logic       evt_type;
   logic [1:0] num;
   logic       pressed;
   logic [1:0] owner;
   logic       evt_busy;
   logic       evt_done;

   int checks = 0;
   int errors = 0;

   feedback_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .sim_req  (sim_req),
      .sim_num  (sim_num),
      .ply_req  (ply_req),
      .ply_num  (ply_num),
      .evt_req  (evt_req),
      .evt_type (evt_type),
      .num      (num),
      .pressed  (pressed),
      .owner    (owner),
      .evt_busy (evt_busy),
      .evt_done (evt_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_po(input string tag, input logic p,
                         input logic [1:0] o);
      chk({tag, ".pressed"}, 32'(pressed), 32'(p));
      chk({tag, ".owner"}, 32'(owner), 32'(o));
   endtask

   logic seen_done;
   logic [1:0] exp_num;

   initial begin
      reset    = 1'b1;
      sim_req  = 1'b0;
      sim_num  = 2'd0;
      ply_req  = 1'b0;
      ply_num  = 2'd0;
      evt_req  = 1'b0;
      evt_type = 1'b0;
      tick();
      tick();
      chk_po("rst", 1'b0, 2'b00);
      chk("rst.num", 32'(num), 0);
      chk("rst.busy", 32'(evt_busy), 0);
      chk("rst.done", 32'(evt_done), 0);
      reset = 1'b0;
      tick();

      // 1-cycle player press
      ply_req = 1'b1;
      ply_num = 2'd2;
      tick();
      ply_req = 1'b0;
      ply_num = 2'd1;
      for (int i = 1; i <= 4; i++) begin
         chk_po("p1.grant", 1'b1, 2'b10);
         chk("p1.num", 32'(num), 2);
         tick();
      end
      for (int i = 5; i <= 6; i++) begin
         chk_po("p1.gap", 1'b0, 2'b00);
         tick();
      end
      chk_po("p1.idle", 1'b0, 2'b00);

      // simultaneous requests, player wins, Simon after gap
      sim_req = 1'b1;
      sim_num = 2'd1;
      ply_req = 1'b1;
      ply_num = 2'd3;
      tick();
      for (int i = 1; i <= 6; i++) begin
         chk_po("p2.ply", 1'b1, 2'b10);
         chk("p2.num", 32'(num), 3);
         if (i == 2) ply_num = 2'd0;
         if (i == 6) ply_req = 1'b0;
         tick();
      end
      for (int i = 7; i <= 9; i++) begin
         chk_po("p2.gap_idle", 1'b0, 2'b00);
         tick();
      end
      chk_po("p2.sim", 1'b1, 2'b01);
      chk("p2.simnum", 32'(num), 1);
      sim_req = 1'b0;
      tick();
      chk_po("p2.sim11", 1'b1, 2'b01);
      ply_req = 1'b1;
      tick();
      chk_po("p2.nopreempt", 1'b1, 2'b01);
      chk("p2.num12", 32'(num), 1);
      ply_req = 1'b0;
      tick();
      chk_po("p2.sim13", 1'b1, 2'b01);
      tick();
      chk_po("p2.gap14", 1'b0, 2'b00);
      tick();
      chk_po("p2.gap15", 1'b0, 2'b00);
      tick();
      tick();
      chk_po("p2.nolatch", 1'b0, 2'b00);

`ifdef FEEDBACK_EVT_JINGLE_EN
      // game-over jingle aborts a Simon grant; retrigger ignored
      sim_req = 1'b1;
      sim_num = 2'd2;
      tick();
      chk_po("e1.sim", 1'b1, 2'b01);
      chk("e1.simnum", 32'(num), 2);
      tick();
      sim_req  = 1'b0;
      evt_req  = 1'b1;
      evt_type = 1'b0;
      tick();
      seen_done = 1'b0;
      for (int k = 3; k <= 34; k++) begin
         exp_num = 2'(3 - (k - 3) / 8);
         chk_po("e1.jingle", 1'b1, 2'b11);
         chk("e1.num", 32'(num), 32'(exp_num));
         chk("e1.busy", 32'(evt_busy), 1);
         if (evt_done) seen_done = 1'b1;
         if (k == 13) begin
            evt_req  = 1'b1;
            evt_type = 1'b1;
         end else begin
            evt_req = 1'b0;
         end
         tick();
      end
      chk("e1.early_done", 32'(seen_done), 0);
      chk("e1.done", 32'(evt_done), 1);
      chk("e1.busy_off", 32'(evt_busy), 0);
      chk_po("e1.gap", 1'b0, 2'b00);
      tick();
      chk("e1.done_once", 32'(evt_done), 0);
      chk_po("e1.gap2", 1'b0, 2'b00);
      tick();
      chk_po("e1.idle", 1'b0, 2'b00);

      // level-up jingle aborted by reset
      evt_req  = 1'b1;
      evt_type = 1'b1;
      tick();
      evt_req = 1'b0;
      chk_po("e2.start", 1'b1, 2'b11);
      chk("e2.num0", 32'(num), 0);
      for (int k = 1; k <= 11; k++) tick();
      chk("e2.num12", 32'(num), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_po("e2.rst", 1'b0, 2'b00);
      chk("e2.rst_num", 32'(num), 0);
      chk("e2.rst_busy", 32'(evt_busy), 0);
      seen_done = evt_done;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (evt_done) seen_done = 1'b1;
      end
      chk("e2.no_done", 32'(seen_done), 0);
      chk_po("e2.idle", 1'b0, 2'b00);
`else
      // without the jingle, an event only echoes a done pulse
      ply_req = 1'b1;
      ply_num = 2'd2;
      tick();
      ply_req = 1'b0;
      chk_po("n1.grant", 1'b1, 2'b10);
      evt_req  = 1'b1;
      evt_type = 1'b1;
      tick();
      evt_req = 1'b0;
      chk("n1.done", 32'(evt_done), 1);
      chk("n1.busy", 32'(evt_busy), 0);
      chk_po("n1.keep", 1'b1, 2'b10);
      chk("n1.num", 32'(num), 2);
      tick();
      chk("n1.done_off", 32'(evt_done), 0);
      chk_po("n1.keep3", 1'b1, 2'b10);
      tick();
      chk_po("n1.keep4", 1'b1, 2'b10);
      tick();
      chk_po("n1.gap", 1'b0, 2'b00);
      tick();
      tick();
      evt_req = 1'b1;
      tick();
      evt_req = 1'b0;
      chk("n2.done", 32'(evt_done), 1);
      chk_po("n2.idle", 1'b0, 2'b00);
      tick();
      chk("n2.done_off", 32'(evt_done), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/feedback_arbiter.md
FEEDBACK_ARBITER -- requirements
Module: feedback_arbiter

Interface
- REQ-001: Parameter MIN_HOLD, default 4: minimum cycles a grant to Simon or player is held.
- REQ-002: Parameter GAP_CYC, default 2: silent cycles inserted after every released grant.
- REQ-003: Parameter NOTE_CYC, default 8: cycles per jingle note.
- REQ-004: clk  in  1  single system clock; all state changes on rising edge.
- REQ-005: reset  in  1  synchronous, active-high reset.
- REQ-006: sim_req  in  1  Simon playback wants the tone/LED resource (level).
- REQ-007: sim_num  in  2  Simon note index.
- REQ-008: ply_req  in  1  player button held (level).
- REQ-009: ply_num  in  2  player note index.
- REQ-010: evt_req  in  1  one-cycle pulse: start event jingle.
- REQ-011: evt_type  in  1  0 = game over, 1 = level up; sampled with evt_req.
- REQ-012: num  out  2  note index driven to LED and frequency decoders.
- REQ-013: pressed  out  1  tone/LED enable.
- REQ-014: owner  out  2  00 idle/gap, 01 Simon, 10 player, 11 event.
- REQ-015: evt_busy  out  1  high while jingle plays.
- REQ-016: evt_done  out  1  one-cycle pulse at jingle completion.

Function
- REQ-017: FSM states IDLE, SIMON, PLAYER, EVENT, GAP; all outputs registered; request-to-pressed latency is one cycle.
- REQ-018: Priority on grant: evt_req > ply_req > sim_req; simultaneous sim_req and ply_req in IDLE grants PLAYER.
- REQ-019: Grants to SIMON/PLAYER occur only from IDLE; num is captured from the winner's *_num at the grant edge and held constant for the whole grant.
- REQ-020: Held-cycle counter starts at 1 in the first granted cycle; grant releases at the first edge where the owner's request is low and counter >= MIN_HOLD; a 1-cycle request therefore yields exactly MIN_HOLD pressed cycles.
- REQ-021: PLAYER does not preempt SIMON and vice versa; a losing request is not latched and must still be high when IDLE is re-entered.
- REQ-022: On release, enter GAP with pressed=0, owner=00 for GAP_CYC cycles, then IDLE; a new grant takes one further edge.
- REQ-023: evt_req in any state (IDLE, SIMON, PLAYER, GAP) enters EVENT on the next edge, aborting the current grant without a GAP.
- REQ-024: EVENT plays 4 notes, each NOTE_CYC cycles, pressed=1 throughout: game over 3,2,1,0; level up 0,1,2,3.
- REQ-025: After the last note: evt_done pulses for one cycle, evt_busy drops the same cycle, FSM enters GAP.
- REQ-026: evt_req while evt_busy=1 is ignored; no restart, no second evt_done.
- REQ-027: Counters sized for value 2^16-1; parameters exceeding that are out of range.

Reset
- REQ-028: While reset is high at a rising edge: state=IDLE, num=0, pressed=0, owner=00, evt_busy=0, evt_done=0, all counters 0.
- REQ-029: Reset mid-grant or mid-jingle aborts immediately; no evt_done is emitted for an aborted jingle.

Configuration
- REQ-030: Macro FEEDBACK_EVT_JINGLE_EN defined: EVENT state and jingle behave per REQ-023..026.
- REQ-031: Macro undefined: no EVENT state; evt_req produces an evt_done pulse one cycle later, evt_busy stays 0, owner never 11, current grant unaffected.

Verification (defaults MIN_HOLD=4, GAP_CYC=2, NOTE_CYC=8, macro defined)
- REQ-032: IDLE, 1-cycle ply_req with ply_num=2 -> pressed=1, owner=10, num=2 for exactly 4 cycles, then 2 cycles pressed=0, owner=00.
- REQ-033: sim_req (sim_num=1) and ply_req (ply_num=3) rise together, ply_req held 6 cycles -> 6 cycles num=3 owner=10, 2 gap cycles, 1 IDLE cycle, then owner=01 num=1.
- REQ-034: evt_req, evt_type=0 during a Simon grant -> next cycle owner=11, num 3,2,1,0 for 8 cycles each, evt_busy high 32 cycles, evt_done pulse on cycle 33, then GAP.
- REQ-035: Second evt_req 10 cycles into a jingle -> sequence unchanged, exactly one evt_done.
- REQ-036: reset at cycle 12 of a level-up jingle -> next cycle all outputs 0, no evt_done ever.
- REQ-037: Macro undefined, evt_req during player grant -> evt_done one cycle later, owner stays 10, pressed unaffected.
